// File: rtl/md_issue_queue_if.sv
// Request channel between the E stage (master) and the MD issue queue (slave).
interface md_issue_queue_if #(
  parameter int OP_W = 4
) ();
  logic            req_valid;
  logic            req_ready;
  logic [OP_W-1:0] req_op;
  logic [31:0]     req_a;
  logic [31:0]     req_b;

  modport master (
    output req_valid,
    output req_op,
    output req_a,
    output req_b,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_op,
    input  req_a,
    input  req_b,
    output req_ready
  );
endinterface

// File: rtl/md_issue_queue.sv
// In-order request buffer and single-pulse issue sequencer in front of the MD unit.
// Optional idle-queue bypass is enabled by defining MDQ_BYPASS_EN.
module md_issue_queue #(
  parameter int DEPTH = 4,
  parameter int OP_W  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  md_issue_queue_if.slave              req_if,
  input  logic                         md_busy,
  output logic                         md_en,
  output logic [OP_W-1:0]              md_op,
  output logic [31:0]                  md_a,
  output logic [31:0]                  md_b,
  input  logic                         rd_req,
  output logic                         rd_ok,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READY = 2'd1,
    ST_GUARD = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              md_en_q, md_en_d;
  logic [OP_W-1:0]   md_op_q, md_op_d;
  logic [31:0]       md_a_q, md_a_d;
  logic [31:0]       md_b_q, md_b_d;

  logic [OP_W-1:0]   op_mem [DEPTH];
  logic [31:0]       a_mem  [DEPTH];
  logic [31:0]       b_mem  [DEPTH];

  logic              req_ready_s;
  logic              bypass_s;
  logic              push_s;
  logic              issue_s;
  logic              unused_rd_req_s;

  // A full queue refuses even when the head is leaving this cycle.
  assign req_ready_s = (count_q != CNT_FULL) && !flush;

`ifdef MDQ_BYPASS_EN
  assign bypass_s = (state_q == ST_IDLE) && (count_q == CNT_ZERO) && !md_busy
                    && !flush && req_if.req_valid;
`else
  assign bypass_s = 1'b0;
`endif

  assign push_s  = req_if.req_valid && req_ready_s && !bypass_s;
  assign issue_s = (state_q == ST_READY) && !md_busy && (count_q != CNT_ZERO);

  assign req_if.req_ready = req_ready_s;
  assign rd_ok            = (state_q == ST_IDLE) && !md_busy;
  // The pipeline itself stalls on rd_req && !rd_ok; nothing here depends on it.
  assign unused_rd_req_s  = rd_req;

  assign count = count_q;
  assign md_en = md_en_q;
  assign md_op = md_op_q;
  assign md_a  = md_a_q;
  assign md_b  = md_b_q;

  // Occupancy and pointer bookkeeping; flush drops everything not yet issued.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (issue_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (flush) begin
      count_d  = CNT_ZERO;
      rd_ptr_d = wr_ptr_q;
    end else begin
      case ({push_s, issue_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Issue sequencing: GUARD covers the edge before md_busy becomes visible.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bypass_s) begin
          state_d = ST_GUARD;
        end else if (push_s) begin
          state_d = ST_READY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READY: begin
        if (issue_s) begin
          state_d = ST_GUARD;
        end else if (count_d == CNT_ZERO) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_READY;
        end
      end
      ST_GUARD: begin
        if (count_d != CNT_ZERO) begin
          state_d = ST_READY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Issued operands hold their last values between pulses.
  always_comb begin
    md_en_d = issue_s || bypass_s;
    md_op_d = md_op_q;
    md_a_d  = md_a_q;
    md_b_d  = md_b_q;
    if (issue_s) begin
      md_op_d = op_mem[rd_ptr_q];
      md_a_d  = a_mem[rd_ptr_q];
      md_b_d  = b_mem[rd_ptr_q];
    end else if (bypass_s) begin
      md_op_d = req_if.req_op;
      md_a_d  = req_if.req_a;
      md_b_d  = req_if.req_b;
    end else begin
      md_op_d = md_op_q;
      md_a_d  = md_a_q;
      md_b_d  = md_b_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push_s) begin
      op_mem[wr_ptr_q] <= req_if.req_op;
      a_mem[wr_ptr_q]  <= req_if.req_a;
      b_mem[wr_ptr_q]  <= req_if.req_b;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      count_q  <= CNT_ZERO;
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      md_en_q  <= 1'b0;
      md_op_q  <= {OP_W{1'b0}};
      md_a_q   <= 32'h0000_0000;
      md_b_q   <= 32'h0000_0000;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      md_en_q  <= md_en_d;
      md_op_q  <= md_op_d;
      md_a_q   <= md_a_d;
      md_b_q   <= md_b_d;
    end
  end

endmodule

// File: tb/tb_md_issue_queue.sv
// Directed self-checking bench for md_issue_queue (default build, no bypass).
module tb_md_issue_queue;
  localparam int DEPTH = 4;
  localparam int OP_W  = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk     = 1'b0;
  logic             reset   = 1'b0;
  logic             md_busy = 1'b0;
  logic             rd_req  = 1'b0;
  logic             flush   = 1'b0;
  logic             md_en;
  logic [OP_W-1:0]  md_op;
  logic [31:0]      md_a;
  logic [31:0]      md_b;
  logic             rd_ok;
  logic [CNT_W-1:0] count;

  int n_checks = 0;
  int n_errors = 0;

  int          pulse_cnt;
  int          pulse_cyc [8];
  logic [31:0] pulse_a   [8];
  logic [3:0]  pulse_op  [8];

  md_issue_queue_if #(.OP_W(OP_W)) req_if ();

  md_issue_queue #(.DEPTH(DEPTH), .OP_W(OP_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .req_if  (req_if),
    .md_busy (md_busy),
    .md_en   (md_en),
    .md_op   (md_op),
    .md_a    (md_a),
    .md_b    (md_b),
    .rd_req  (rd_req),
    .rd_ok   (rd_ok),
    .flush   (flush),
    .count   (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_if.req_valid = 1'b1;
    req_if.req_op    = op;
    req_if.req_a     = a;
    req_if.req_b     = b;
    edge_step();
    req_if.req_valid = 1'b0;
  endtask

  task automatic watch(input int n);
    pulse_cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (md_en === 1'b1 && pulse_cnt < 8) begin
        pulse_cyc[pulse_cnt] = k;
        pulse_a[pulse_cnt]   = md_a;
        pulse_op[pulse_cnt]  = md_op;
        pulse_cnt++;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    req_if.req_valid = 1'b0;
    req_if.req_op    = 4'h0;
    req_if.req_a     = 32'h0;
    req_if.req_b     = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_count", 32'(count), 32'd0);
    check("rst_md_en", 32'(md_en), 32'd0);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_rd_ok", 32'(rd_ok), 32'd1);
    check("rst_ready", 32'(req_if.req_ready), 32'd1);
    check("rst_md_a", md_a, 32'd0);

    // Single mult into idle queue: pulse in the cycle after E1
    rd_req = 1'b1;
    push_req(4'h1, 32'd3, 32'd5);
    @(negedge clk);
    check("t1_count_e0", 32'(count), 32'd1);
    check("t1_en_e0", 32'(md_en), 32'd0);
    check("t1_rdok_e0", 32'(rd_ok), 32'd0);
    edge_step();
    @(negedge clk);
    check("t1_en_e1", 32'(md_en), 32'd1);
    check("t1_md_a", md_a, 32'd3);
    check("t1_md_b", md_b, 32'd5);
    check("t1_md_op", 32'(md_op), 32'd1);
    check("t1_count_e1", 32'(count), 32'd0);
    edge_step();
    md_busy = 1'b1;
    @(negedge clk);
    check("t1_en_drop", 32'(md_en), 32'd0);
    check("t1_rdok_busy", 32'(rd_ok), 32'd0);
    check("t1_a_hold", md_a, 32'd3);
    repeat (3) edge_step();
    md_busy = 1'b0;
    @(negedge clk);
    check("t1_rdok_free", 32'(rd_ok), 32'd1);
    rd_req = 1'b0;

    // Fill with busy held, fifth push refused, then drain in order
    md_busy = 1'b1;
    for (int i = 0; i < 4; i++) push_req(4'(i + 2), 32'(10 + i), 32'(20 + i));
    @(negedge clk);
    check("t2_count_full", 32'(count), 32'd4);
    check("t2_ready_full", 32'(req_if.req_ready), 32'd0);
    check("t2_en_busy", 32'(md_en), 32'd0);
    push_req(4'h7, 32'd99, 32'd99);
    @(negedge clk);
    check("t2_count_refused", 32'(count), 32'd4);
    md_busy = 1'b0;
    watch(14);
    check("t2_pulses", 32'(pulse_cnt), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("t2_order_a", pulse_a[i], 32'(10 + i));
      check("t2_order_op", 32'(pulse_op[i]), 32'(i + 2));
    end
    for (int i = 1; i < 4; i++) check("t2_spacing", 32'(pulse_cyc[i] - pulse_cyc[i-1]), 32'd2);
    check("t2_count_end", 32'(count), 32'd0);

    // mthi then mtlo back to back: pulses exactly two cycles apart
    push_req(4'h8, 32'h11, 32'h0);
    push_req(4'h9, 32'h22, 32'h0);
    watch(8);
    check("t3_pulses", 32'(pulse_cnt), 32'd2);
    check("t3_spacing", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd2);
    check("t3_op0", 32'(pulse_op[0]), 32'h8);
    check("t3_op1", 32'(pulse_op[1]), 32'h9);
    check("t3_a0", pulse_a[0], 32'h11);
    check("t3_a1", pulse_a[1], 32'h22);

    // Full queue, pop and push offered together: push refused
    md_busy = 1'b1;
    for (int i = 0; i < 4; i++) push_req(4'h3, 32'(32'h40 + i), 32'h0);
    @(negedge clk);
    check("t4_count_full", 32'(count), 32'd4);
    md_busy = 1'b0;
    req_if.req_valid = 1'b1;
    req_if.req_op    = 4'hF;
    req_if.req_a     = 32'h77;
    #1;
    check("t4_ready_full", 32'(req_if.req_ready), 32'd0);
    edge_step();
    req_if.req_valid = 1'b0;
    @(negedge clk);
    check("t4_count_pop", 32'(count), 32'd3);
    check("t4_en", 32'(md_en), 32'd1);
    check("t4_head", md_a, 32'h40);
    watch(12);
    check("t4_pulses", 32'(pulse_cnt), 32'd3);
    check("t4_last", pulse_a[2], 32'h43);
    check("t4_count_end", 32'(count), 32'd0);

    // Flush with three queued while one is in flight
    md_busy = 1'b1;
    for (int i = 0; i < 4; i++) push_req(4'h4, 32'(32'h50 + i), 32'h0);
    md_busy = 1'b0;
    edge_step();
    md_busy = 1'b1;
    flush   = 1'b1;
    @(negedge clk);
    check("t5_en", 32'(md_en), 32'd1);
    check("t5_inflight", md_a, 32'h50);
    check("t5_count_pre", 32'(count), 32'd3);
    check("t5_ready_flush", 32'(req_if.req_ready), 32'd0);
    edge_step();
    flush = 1'b0;
    @(negedge clk);
    check("t5_count_flush", 32'(count), 32'd0);
    check("t5_en_drop", 32'(md_en), 32'd0);
    check("t5_a_hold", md_a, 32'h50);
    repeat (2) edge_step();
    md_busy = 1'b0;
    @(negedge clk);
    check("t5_rdok", 32'(rd_ok), 32'd1);
    watch(8);
    check("t5_no_issue", 32'(pulse_cnt), 32'd0);

    // Flush in the same cycle as an issue: the issue completes, nothing after
    md_busy = 1'b1;
    push_req(4'h5, 32'h60, 32'h0);
    push_req(4'h5, 32'h61, 32'h0);
    md_busy = 1'b0;
    flush   = 1'b1;
    edge_step();
    flush = 1'b0;
    @(negedge clk);
    check("t5b_en", 32'(md_en), 32'd1);
    check("t5b_a", md_a, 32'h60);
    check("t5b_count", 32'(count), 32'd0);
    watch(8);
    check("t5b_no_issue", 32'(pulse_cnt), 32'd0);
    check("t5b_rdok", 32'(rd_ok), 32'd1);

    // Reset in the middle of a non-empty queue
    md_busy = 1'b1;
    push_req(4'h6, 32'h70, 32'h0);
    push_req(4'h6, 32'h71, 32'h0);
    @(negedge clk);
    check("t6_count_pre", 32'(count), 32'd2);
    reset = 1'b0;
    #1;
    check("t6_count_rst", 32'(count), 32'd0);
    check("t6_en_rst", 32'(md_en), 32'd0);
    edge_step();
    reset   = 1'b1;
    md_busy = 1'b0;
    @(negedge clk);
    check("t6_count_post", 32'(count), 32'd0);
    check("t6_rdok_post", 32'(rd_ok), 32'd1);
    check("t6_a_post", md_a, 32'd0);
    check("t6_op_post", 32'(md_op), 32'd0);
    watch(6);
    check("t6_no_issue", 32'(pulse_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/md_issue_queue.md
# md_issue_queue

Request buffer and issue sequencer directly upstream of the multiply/divide unit. Accepts HI/LO-modifying operations (mult, multu, div, divu, mthi, mtlo, madd-class) from the E stage and holds up to DEPTH of them in order. Issues each one to the MD unit as a single-cycle `en` pulse, only when the unit can accept it. Also tells the pipeline when an mfhi/mflo read can proceed, so the E stage stalls only on reads, not on every MDU instruction.

## Interface
Parameters:
- DEPTH, 4, queue entries; power of two, ≥2
- OP_W, 4, width of MD operation code (matches MD unit `MDop`)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  E stage presents an MDU request
- req_ready  out  1  queue accepts request this cycle
- req_op  in  OP_W  operation code, opaque to this block
- req_a  in  32  operand A (rs value)
- req_b  in  32  operand B (rt value)
- md_busy  in  1  MD unit `busy`
- md_en  out  1  one-cycle issue pulse to MD unit `en`
- md_op  out  OP_W  issued opcode to MD unit `MDop`
- md_a  out  32  issued operand A
- md_b  out  32  issued operand B
- rd_req  in  1  mfhi/mflo present in E stage
- rd_ok  out  1  HI/LO read is safe this cycle
- flush  in  1  synchronous discard of queued (not yet issued) entries
- count  out  $clog2(DEPTH+1)  entries currently queued

## Operation
- FIFO order, with a circular write pointer and read pointer; wrap at DEPTH. `count` is registered.
- req_ready = (count != DEPTH) && !flush.
  - A full queue refuses a push even when a pop happens in the same cycle.
- Push and pop in the same cycle: count is unchanged.
- FSM states:
  - IDLE: count==0, nothing in flight.
  - READY: head entry valid.
  - GUARD: issued last edge; md_busy is not yet visible.
- FSM transitions:
  - IDLE→READY on a push.
  - READY with !md_busy: pop head, register md_op/md_a/md_b, set md_en=1, go to GUARD.
  - READY with md_busy: hold.
  - GUARD→READY if count>0 after that edge, else →IDLE. md_en returns to 0.
- GUARD never issues. This is required because the MD unit raises busy one edge after `en`, and it ignores requests while busy.
- md_op/md_a/md_b hold their last issued values between pulses.
- rd_ok = (state==IDLE) && !md_busy.
  - rd_req is informational only; the pipeline stalls on rd_req && !rd_ok.
- flush:
  - Effect: count←0 and pointers equalised.
  - Timing: any issue decided in the same cycle still completes. An operation already issued is unaffected.
  - Next state: GUARD if an issue occurred, else IDLE.
- reset low forces:
  - count=0, pointers=0, state=IDLE
  - md_en=0, md_op=0, md_a=0, md_b=0
- Mid-operation reset: queue contents are lost, and there is no pending issue after release.

## Timing
- Without bypass: request accepted at edge E0, md_en high in the cycle after E1.
- Minimum spacing between md_en pulses is 2 cycles (issue, then GUARD).
  - Back-to-back mult operations are further spaced by md_busy (5 cycles for mult, 10 for div in the MD unit).
- rd_ok falls in the cycle after the accepting edge. It rises no earlier than the first cycle where the state is IDLE and md_busy is low.
- All outputs are registered except req_ready and rd_ok (combinational from registers and flush).

## Configuration
- MDQ_BYPASS_EN defined:
  - Condition: when state==IDLE, count==0, !md_busy, !flush and req_valid.
  - Effect: the request is not written into the FIFO. It is loaded straight into md_*, with md_en high in the cycle after E0, and the FSM goes to GUARD.
- MDQ_BYPASS_EN undefined: every request passes through the FIFO, giving the latency stated above.

## Test plan
- Single mult A=3, B=5 into idle queue → md_en pulse one cycle after E1 (E0 with bypass) with md_a=3, md_b=5; rd_ok low until md_busy clears, then high.
- Push 4 requests with md_busy held 1 → count=4, req_ready=0, a fifth push is refused; release md_busy → issued in push order with ≥2-cycle spacing, count decrements to 0.
- mthi 0x11 then mtlo 0x22 with md_busy=0 → two md_en pulses exactly 2 cycles apart, ops in order.
- Full queue, pop and push request in the same cycle → push refused, count 4→3.
- flush with 3 queued while one is in flight → count=0 next edge, in-flight op completes, no further md_en.
- Assert reset low mid-queue (count=2) → count=0, md_en=0, rd_ok=1 on md_busy=0 after release.
